// File: rtl/writeback_pkg.sv
// Shared constants, types and helpers for the writeback stage.
// Holds pipeline field widths, the opcode constants the stage decodes,
// and the FSM state encodings.
package writeback_pkg;

   // Field MSBs of the retiring-instruction bundle
   localparam int ADDR_SIZE     = 31;
   localparam int INSTR_SIZE    = 31;
   localparam int REG_DATA_SIZE = 31;
   localparam int REG_ADDR_SIZE = 4;
   localparam int EX_WIDTH      = 3;

   typedef logic [ADDR_SIZE:0]     pc_t;
   typedef logic [INSTR_SIZE:0]    instr_t;
   typedef logic [REG_DATA_SIZE:0] reg_data_t;
   typedef logic [REG_ADDR_SIZE:0] reg_addr_t;
   typedef logic [EX_WIDTH:0]      ex_cause_t;
   typedef logic [4:0]             opcode_t;

   // RV32 major opcodes, bits [6:2] of the instruction word
   localparam opcode_t OP_LOAD   = 5'b00000;
   localparam opcode_t OP_IMM    = 5'b00100;
   localparam opcode_t OP_AUIPC  = 5'b00101;
   localparam opcode_t OP_STORE  = 5'b01000;
   localparam opcode_t OP_OP     = 5'b01100;
   localparam opcode_t OP_LUI    = 5'b01101;
   localparam opcode_t OP_BRANCH = 5'b11000;
   localparam opcode_t OP_JALR   = 5'b11001;
   localparam opcode_t OP_JAL    = 5'b11011;
   localparam opcode_t OP_SYSTEM = 5'b11100;

   // FSM encodings
   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_TRAP   = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   // Stores and branches carry an rd field that is not a destination;
   // x0 is hard-wired to zero and bubbles never write.
   function automatic logic writes_rd(input opcode_t opc,
                                      input reg_addr_t rd,
                                      input logic nop);
      return !nop && (rd != '0) && (opc != OP_STORE) && (opc != OP_BRANCH);
   endfunction

endpackage

// File: rtl/writeback_if.sv
// Retire bus between the memory stage (master) and writeback (slave).
// Carries the retiring instruction bundle in, and the register-file write
// port, trap record, pipeline control and retire count out.
interface writeback_if;
   import writeback_pkg::*;

   // memory stage -> writeback
   pc_t       PC_in;
   instr_t    instr_in;
   opcode_t   opcode_in;
   logic [2:0] funct_in;
   logic      nop_instr_in;
   reg_data_t result_in;
   reg_addr_t rd_addr_in;
   logic      pipeline_in_valid;
   ex_cause_t exception_in;
   logic      exception_in_valid;
   logic      halt_in;

   // writeback -> register file / pipeline
   logic        rf_wr_en;
   reg_addr_t   rf_wr_addr;
   reg_data_t   rf_wr_data;
   logic        trap_valid;
   pc_t         trap_pc;
   ex_cause_t   trap_cause;
   logic        flush_out;
   logic        stall_out;
   logic        halted;
   logic [63:0] instret;

   modport master (
      output PC_in, instr_in, opcode_in, funct_in, nop_instr_in, result_in,
             rd_addr_in, pipeline_in_valid, exception_in, exception_in_valid,
             halt_in,
      input  rf_wr_en, rf_wr_addr, rf_wr_data, trap_valid, trap_pc,
             trap_cause, flush_out, stall_out, halted, instret
   );

   modport slave (
      input  PC_in, instr_in, opcode_in, funct_in, nop_instr_in, result_in,
             rd_addr_in, pipeline_in_valid, exception_in, exception_in_valid,
             halt_in,
      output rf_wr_en, rf_wr_addr, rf_wr_data, trap_valid, trap_pc,
             trap_cause, flush_out, stall_out, halted, instret
   );

endinterface

// File: rtl/writeback_retire_counter.sv
// Retired-instruction counter: 64-bit, increments by one when i_en is high.
// Latency: count visible the cycle after the enabling edge; wraps to zero.
// Ports: clk, reset (async active-low), i_en, o_count. No backpressure.
module writeback_retire_counter (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_en,
   output logic [63:0] o_count
);

   logic [63:0] r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + 64'd1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/writeback.sv
// Writeback: commits retiring results to the RF, counts retires, turns
// exceptions/halts into flush/stall/halted. Latency: all outputs registered, 1 cycle.
// Backpressure: drops input while trapping or halted; raises stall_out in those states.
// Ports: clk, reset (async active-low), wb (writeback_if.slave retire bus).
module writeback
   import writeback_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   writeback_if.slave wb
);

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;

   logic        r_rf_wr_en;
   reg_addr_t   r_rf_wr_addr;
   reg_data_t   r_rf_wr_data;
   logic        r_trap_valid;
   pc_t         r_trap_pc;
   ex_cause_t   r_trap_cause;
   logic        r_flush;
   logic        r_stall;
   logic        r_halted;

   logic        w_accept;
   logic        w_exc;
   logic        w_retire;
   logic        w_count;
   logic [63:0] w_instret;

   // Instruction word and funct3 travel with the bundle for debug visibility
   // only; nothing at this stage decodes them.
   logic        w_unused;
   assign w_unused = ^{wb.instr_in, wb.funct_in};

   assign w_accept = wb.pipeline_in_valid && (r_state == ST_RUN);
   // Exception takes priority over halt on the same beat
   assign w_exc    = w_accept && wb.exception_in_valid;
   assign w_retire = w_accept && !wb.exception_in_valid;
   assign w_count  = w_retire && !wb.nop_instr_in;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_exc) begin
               w_state_nxt = ST_TRAP;
            end else if (w_retire && wb.halt_in) begin
               w_state_nxt = ST_HALTED;
            end
         end
         ST_TRAP:   w_state_nxt = ST_RUN;
         ST_HALTED: w_state_nxt = ST_HALTED;
         default:   w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_RUN;
         r_rf_wr_en   <= 1'b0;
         r_rf_wr_addr <= '0;
         r_rf_wr_data <= '0;
         r_trap_valid <= 1'b0;
         r_trap_pc    <= '0;
         r_trap_cause <= '0;
         r_flush      <= 1'b0;
         r_stall      <= 1'b0;
         r_halted     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         // Strobe is recomputed every cycle so it never lingers
         r_rf_wr_en <= w_retire &&
                       writes_rd(wb.opcode_in, wb.rd_addr_in, wb.nop_instr_in);
         if (w_retire) begin
            r_rf_wr_addr <= wb.rd_addr_in;
            r_rf_wr_data <= wb.result_in;
         end

         // Trap record is sticky; a later fault overwrites PC and cause
         if (w_exc) begin
            r_trap_valid <= 1'b1;
            r_trap_pc    <= wb.PC_in;
            r_trap_cause <= wb.exception_in;
         end

         // Control outputs reflect the state being entered, so they are
         // aligned with the TRAP/HALTED cycles themselves.
         r_flush  <= (w_state_nxt == ST_TRAP);
         r_stall  <= (w_state_nxt == ST_TRAP) || (w_state_nxt == ST_HALTED);
         r_halted <= (w_state_nxt == ST_HALTED);
      end
   end

   writeback_retire_counter u_retire (
      .clk     (clk),
      .reset   (reset),
      .i_en    (w_count),
      .o_count (w_instret)
   );

   assign wb.rf_wr_en   = r_rf_wr_en;
   assign wb.rf_wr_addr = r_rf_wr_addr;
   assign wb.rf_wr_data = r_rf_wr_data;
   assign wb.trap_valid = r_trap_valid;
   assign wb.trap_pc    = r_trap_pc;
   assign wb.trap_cause = r_trap_cause;
   assign wb.flush_out  = r_flush;
   assign wb.stall_out  = r_stall;
   assign wb.halted     = r_halted;
   assign wb.instret    = w_instret;

endmodule

// File: tb/tb_writeback.sv
// Testbench for writeback: directed and random retire streams checked
// against a behavioural model through an expectation queue.
module tb_writeback;
   import writeback_pkg::*;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   writeback_if wbif ();

   writeback dut (
      .clk   (clk),
      .reset (reset),
      .wb    (wbif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr_en;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        tv;
      logic [31:0] tpc;
      logic [3:0]  tc;
      logic        flush;
      logic        stall;
      logic        halted;
      logic [63:0] instret;
   } exp_t;

   exp_t q[$];

   // Behavioural model state
   logic [63:0] m_instret;
   logic        m_tv;
   logic [31:0] m_tpc;
   logic [3:0]  m_tc;
   logic        m_halted;
   logic        m_in_trap;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every registered output update is compared with the
   // expectation queued when the corresponding beat was driven.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("rf_wr_en", {63'd0, wbif.rf_wr_en}, {63'd0, e.wr_en});
            if (e.wr_en) begin
               check("rf_wr_addr", {59'd0, wbif.rf_wr_addr}, {59'd0, e.addr});
               check("rf_wr_data", {32'd0, wbif.rf_wr_data}, {32'd0, e.data});
            end
            check("trap_valid", {63'd0, wbif.trap_valid}, {63'd0, e.tv});
            if (e.tv) begin
               check("trap_pc", {32'd0, wbif.trap_pc}, {32'd0, e.tpc});
               check("trap_cause", {60'd0, wbif.trap_cause}, {60'd0, e.tc});
            end
            check("flush_out", {63'd0, wbif.flush_out}, {63'd0, e.flush});
            check("stall_out", {63'd0, wbif.stall_out}, {63'd0, e.stall});
            check("halted", {63'd0, wbif.halted}, {63'd0, e.halted});
            check("instret", wbif.instret, e.instret);
         end
      end
   end

   task automatic model_reset();
      m_instret = '0;
      m_tv      = 1'b0;
      m_tpc     = '0;
      m_tc      = '0;
      m_halted  = 1'b0;
      m_in_trap = 1'b0;
   endtask

   // Called at a falling edge: present one cycle of input, queue the
   // expected outputs after the next rising edge, advance to next falling edge.
   task automatic beat(input logic vld, input logic [31:0] pc,
                       input logic [4:0] opc, input logic nop,
                       input logic [31:0] res, input logic [4:0] rd,
                       input logic exv, input logic [3:0] exc,
                       input logic halt);
      exp_t e;
      logic acc;
      logic trap_next;
      wbif.pipeline_in_valid  = vld;
      wbif.PC_in              = pc;
      wbif.instr_in           = $urandom;
      wbif.opcode_in          = opc;
      wbif.funct_in           = 3'($urandom);
      wbif.nop_instr_in       = nop;
      wbif.result_in          = res;
      wbif.rd_addr_in         = rd;
      wbif.exception_in_valid = exv;
      wbif.exception_in       = exc;
      wbif.halt_in            = halt;

      acc       = vld && !m_halted && !m_in_trap;
      trap_next = 1'b0;
      e.wr_en   = 1'b0;
      e.addr    = rd;
      e.data    = res;
      e.flush   = 1'b0;
      if (acc) begin
         if (exv) begin
            m_tv      = 1'b1;
            m_tpc     = pc;
            m_tc      = exc;
            trap_next = 1'b1;
            e.flush   = 1'b1;
         end else begin
            e.wr_en = !nop && (rd != 5'd0) && (opc != OP_STORE) && (opc != OP_BRANCH);
            if (!nop) m_instret = m_instret + 64'd1;
            if (halt) m_halted = 1'b1;
         end
      end
      m_in_trap = trap_next;
      e.tv      = m_tv;
      e.tpc     = m_tpc;
      e.tc      = m_tc;
      e.stall   = m_in_trap || m_halted;
      e.halted  = m_halted;
      e.instret = m_instret;
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle();
      beat(1'b0, 32'h0, OP_OP, 1'b0, 32'h0, 5'd0, 1'b0, 4'd0, 1'b0);
   endtask

   // Called at a falling edge; asynchronous reset must clear outputs at once.
   task automatic do_reset(input string tag);
      wbif.pipeline_in_valid = 1'b0;
      reset = 1'b0;
      #1;
      check({tag, "_wr_en"},  {63'd0, wbif.rf_wr_en}, 64'd0);
      check({tag, "_wr_addr"}, {59'd0, wbif.rf_wr_addr}, 64'd0);
      check({tag, "_wr_data"}, {32'd0, wbif.rf_wr_data}, 64'd0);
      check({tag, "_trap_valid"}, {63'd0, wbif.trap_valid}, 64'd0);
      check({tag, "_trap_pc"}, {32'd0, wbif.trap_pc}, 64'd0);
      check({tag, "_trap_cause"}, {60'd0, wbif.trap_cause}, 64'd0);
      check({tag, "_flush"},  {63'd0, wbif.flush_out}, 64'd0);
      check({tag, "_stall"},  {63'd0, wbif.stall_out}, 64'd0);
      check({tag, "_halted"}, {63'd0, wbif.halted}, 64'd0);
      check({tag, "_instret"}, wbif.instret, 64'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      model_reset();
      reset = 1'b0;
      wbif.pipeline_in_valid  = 1'b0;
      wbif.PC_in              = '0;
      wbif.instr_in           = '0;
      wbif.opcode_in          = '0;
      wbif.funct_in           = '0;
      wbif.nop_instr_in       = 1'b0;
      wbif.result_in          = '0;
      wbif.rd_addr_in         = '0;
      wbif.exception_in_valid = 1'b0;
      wbif.exception_in       = '0;
      wbif.halt_in            = 1'b0;
      @(negedge clk);
      do_reset("init");

      // Basic retire with write
      beat(1'b1, 32'h100, OP_OP, 1'b0, 32'hDEADBEEF, 5'd5, 1'b0, 4'd0, 1'b0);
      // Non-writing retires: x0, store, branch (counted), bubble (not counted)
      beat(1'b1, 32'h104, OP_OP,     1'b0, 32'h1111, 5'd0, 1'b0, 4'd0, 1'b0);
      beat(1'b1, 32'h108, OP_STORE,  1'b0, 32'h2222, 5'd3, 1'b0, 4'd0, 1'b0);
      beat(1'b1, 32'h10C, OP_BRANCH, 1'b0, 32'h3333, 5'd4, 1'b0, 4'd0, 1'b0);
      beat(1'b1, 32'h110, OP_OP,     1'b1, 32'h4444, 5'd6, 1'b0, 4'd0, 1'b0);
      // Back-to-back writers keep the strobe high
      beat(1'b1, 32'h114, OP_IMM, 1'b0, 32'hA1, 5'd1, 1'b0, 4'd0, 1'b0);
      beat(1'b1, 32'h118, OP_LUI, 1'b0, 32'hA2, 5'd2, 1'b0, 4'd0, 1'b0);
      idle();
      // Exception beats halt request; beat during TRAP is dropped
      beat(1'b1, 32'h200, OP_OP, 1'b0, 32'h99, 5'd8, 1'b1, 4'd2, 1'b1);
      beat(1'b1, 32'h204, OP_OP, 1'b0, 32'h98, 5'd9, 1'b0, 4'd0, 1'b0);
      idle();
      // Second fault overwrites the trap record
      beat(1'b1, 32'h300, OP_LOAD, 1'b0, 32'h0, 5'd10, 1'b1, 4'd7, 1'b0);
      idle();
      // Halting instruction still retires, then everything is ignored
      beat(1'b1, 32'h400, OP_OP, 1'b0, 32'h55, 5'd7, 1'b0, 4'd0, 1'b1);
      for (int i = 0; i < 3; i++)
         beat(1'b1, 32'h404 + 32'(i * 4), OP_OP, 1'b0, 32'h66, 5'd11, 1'b0, 4'd0, 1'b0);
      do_reset("rst_halted");
      // FSM back in RUN: a beat retires straight away
      beat(1'b1, 32'h500, OP_JAL, 1'b0, 32'h504, 5'd1, 1'b0, 4'd0, 1'b0);

      // Counter wrap
      force dut.u_retire.r_count = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.u_retire.r_count;
      m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      check("force_preload", wbif.instret, m_instret);
      beat(1'b1, 32'h508, OP_OP, 1'b0, 32'h77, 5'd12, 1'b0, 4'd0, 1'b0);
      idle();

      // Reset during the TRAP cycle
      beat(1'b1, 32'h600, OP_OP, 1'b0, 32'h0, 5'd3, 1'b1, 4'd5, 1'b0);
      do_reset("rst_trap");
      beat(1'b1, 32'h604, OP_OP, 1'b0, 32'h88, 5'd13, 1'b0, 4'd0, 1'b0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         if (m_halted && ($urandom_range(0, 3) == 0)) begin
            do_reset("rst_rand");
         end else begin
            logic [4:0] opc;
            logic [4:0] rd;
            case ($urandom_range(0, 3))
               0: opc = OP_STORE;
               1: opc = OP_BRANCH;
               2: opc = OP_OP;
               default: opc = 5'($urandom);
            endcase
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            beat($urandom_range(0, 3) != 0, $urandom, opc,
                 $urandom_range(0, 7) == 0, $urandom, rd,
                 $urandom_range(0, 15) == 0, 4'($urandom),
                 $urandom_range(0, 40) == 0);
         end
      end

      idle();
      @(negedge clk);
      check("queue_drain", 64'(q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
